// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared tile geometry, requester indices and scheduler state encoding
package snake_pkg;

    localparam int XDIM    = 10;
    localparam int YDIM    = 10;
    localparam int XSCREEN = 160;
    localparam int YSCREEN = 120;

    // Counter width covers tile dimensions up to 16
    localparam int CW = 4;

    localparam logic [1:0] REQ_ERASE = 2'd0;
    localparam logic [1:0] REQ_HEAD  = 2'd1;
    localparam logic [1:0] REQ_APPLE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_FIN  = 2'd2
    } sched_state_t;

    function automatic logic [1:0] lowest_req(input logic [2:0] r);
        if (r[0])      return REQ_ERASE;
        else if (r[1]) return REQ_HEAD;
        else           return REQ_APPLE;
    endfunction

endpackage

// File: rtl/tile_scan_counter.sv
// rtl/tile_scan_counter.sv - row-major XC/YC tile scan counter with load and enable
module tile_scan_counter #(
    parameter int XDIM = 10,
    parameter int YDIM = 10,
    parameter int CW   = 4
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          load,
    input  logic          en,
    output logic [CW-1:0] nxt_xc,
    output logic [CW-1:0] nxt_yc,
    output logic          last_pixel
);

    logic [CW-1:0] xc;
    logic [CW-1:0] yc;
    logic          last_col;

    assign last_col   = (xc == CW'(XDIM - 1));
    assign last_pixel = last_col && (yc == CW'(YDIM - 1));

    // Next values are exported so the owner can register the pixel it will show next cycle
    always_comb begin
        nxt_xc = xc;
        nxt_yc = yc;
        if (load) begin
            nxt_xc = '0;
            nxt_yc = '0;
        end else if (en) begin
            if (last_col) begin
                nxt_xc = '0;
                nxt_yc = last_pixel ? '0 : yc + CW'(1);
            end else begin
                nxt_xc = xc + CW'(1);
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            xc <= '0;
            yc <= '0;
        end else begin
            xc <= nxt_xc;
            yc <= nxt_yc;
        end
    end

endmodule

// File: rtl/tile_plot_scheduler.sv
// rtl/tile_plot_scheduler.sv - fixed-priority tile arbiter and pixel scanner for the VGA plot port
module tile_plot_scheduler #(
    parameter int XDIM    = snake_pkg::XDIM,
    parameter int YDIM    = snake_pkg::YDIM,
    parameter int XSCREEN = snake_pkg::XSCREEN,
    parameter int YSCREEN = snake_pkg::YSCREEN
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [2:0]  req,
    input  logic [23:0] req_x,
    input  logic [20:0] req_y,
    input  logic [8:0]  req_colour,
    output logic [2:0]  ack,
    output logic [2:0]  done,
    output logic        busy,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        plot
);
    import snake_pkg::*;

    sched_state_t  state, state_d;
    logic [1:0]    grant, g_sel;
    logic [7:0]    bx, sel_x, base_x;
    logic [6:0]    by, sel_y, base_y;
    logic [2:0]    col, sel_col;
    logic [CW-1:0] nxt_xc, nxt_yc;
    logic          last_pixel, emit, plot_d;
    logic [2:0]    ack_d, done_d;
    logic [8:0]    sum_x;
    logic [7:0]    sum_y;

    tile_scan_counter #(.XDIM(XDIM), .YDIM(YDIM), .CW(CW)) u_scan (
        .Clock      (Clock),
        .Reset      (Reset),
        .load       (state == S_IDLE),
        .en         (state == S_DRAW),
        .nxt_xc     (nxt_xc),
        .nxt_yc     (nxt_yc),
        .last_pixel (last_pixel)
    );

    assign g_sel = lowest_req(req);
    assign busy  = (state != S_IDLE);

    always_comb begin
        unique case (g_sel)
            REQ_ERASE: begin sel_x = req_x[7:0];   sel_y = req_y[6:0];   sel_col = req_colour[2:0]; end
            REQ_HEAD:  begin sel_x = req_x[15:8];  sel_y = req_y[13:7];  sel_col = req_colour[5:3]; end
            default:   begin sel_x = req_x[23:16]; sel_y = req_y[20:14]; sel_col = req_colour[8:6]; end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:  if (|req) state_d = S_DRAW;
            S_DRAW:  if (last_pixel) state_d = S_FIN;
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the coming cycle; the grant cycle already presents pixel (0,0)
    always_comb begin
        emit   = 1'b0;
        ack_d  = '0;
        done_d = '0;
        base_x = bx;
        base_y = by;
        unique case (state)
            S_IDLE: if (|req) begin
                emit   = 1'b1;
                ack_d  = 3'b001 << g_sel;
                base_x = sel_x;
                base_y = sel_y;
            end
            S_DRAW: begin
                if (last_pixel) done_d = 3'b001 << grant;
                else            emit   = 1'b1;
            end
            default: ;
        endcase
        sum_x  = {1'b0, base_x} + 9'(nxt_xc);
        sum_y  = {1'b0, base_y} + 8'(nxt_yc);
        plot_d = emit && (sum_x < 9'(XSCREEN)) && (sum_y < 8'(YSCREEN));
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            grant <= '0;
            bx    <= '0;
            by    <= '0;
            col   <= '0;
        end else if (state == S_IDLE && |req) begin
            grant <= g_sel;
            bx    <= sel_x;
            by    <= sel_y;
            col   <= sel_col;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ack        <= '0;
            done       <= '0;
            plot       <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            ack  <= ack_d;
            done <= done_d;
            plot <= plot_d;
            if (plot_d) begin
                vga_x      <= sum_x[7:0];
                vga_y      <= sum_y[6:0];
                vga_colour <= (state == S_IDLE) ? sel_col : col;
            end
        end
    end

endmodule

// File: tb/tb_tile_plot_scheduler.sv
// tb/tb_tile_plot_scheduler.sv - scoreboard bench for tile_plot_scheduler
module tb_tile_plot_scheduler;
    import snake_pkg::*;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [2:0]  req = '0;
    logic [23:0] req_x = '0;
    logic [20:0] req_y = '0;
    logic [8:0]  req_colour = '0;
    logic [2:0]  ack, done;
    logic        busy, plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;

    tile_plot_scheduler dut (
        .Clock(Clock), .Reset(Reset), .req(req), .req_x(req_x), .req_y(req_y),
        .req_colour(req_colour), .ack(ack), .done(done), .busy(busy),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .plot(plot)
    );

    always #10 Clock = ~Clock;

    typedef struct { int cyc; logic [7:0] x; logic [6:0] y; logic [2:0] c; } pix_t;
    typedef struct { int cyc; logic [2:0] v; } ev_t;

    pix_t pix_q[$];
    ev_t  ack_q[$];
    ev_t  done_q[$];

    int   cyc = 0;
    int   m_rem = 0;
    bit   m_busy = 1'b0;
    bit   armed = 1'b0;
    logic [7:0] last_x = '0;
    logic [6:0] last_y = '0;
    logic [2:0] last_c = '0;
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: a granted tile is a list of on-screen pixels plus ack/done at fixed offsets
    always @(posedge Clock) begin
        int g, ox, oy, sx, sy;
        logic [2:0] c;
        cyc++;
        if (Reset) begin
            m_rem = 0;
            pix_q.delete();
            ack_q.delete();
            done_q.delete();
            last_x = '0; last_y = '0; last_c = '0;
            armed = 1'b1;
        end else if (m_rem > 0) begin
            m_rem--;
        end else if (req != 3'b000) begin
            g  = req[0] ? 0 : (req[1] ? 1 : 2);
            ox = int'(req_x[8*g +: 8]);
            oy = int'(req_y[7*g +: 7]);
            c  = req_colour[3*g +: 3];
            ack_q.push_back('{cyc, 3'(1 << g)});
            for (int k = 0; k < XDIM*YDIM; k++) begin
                sx = ox + k % XDIM;
                sy = oy + k / XDIM;
                if (sx < XSCREEN && sy < YSCREEN)
                    pix_q.push_back('{cyc + k, 8'(sx), 7'(sy), c});
            end
            done_q.push_back('{cyc + XDIM*YDIM, 3'(1 << g)});
            m_rem = XDIM*YDIM + 1;
        end
        m_busy = (m_rem > 0);
    end

    always @(negedge Clock) begin
        pix_t p;
        ev_t  e;
        if (armed) begin
            vectors++;
            if (busy !== m_busy) begin
                miscompares++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_busy);
            end
            while (pix_q.size() > 0 && pix_q[0].cyc < cyc) begin
                p = pix_q.pop_front();
                vectors++; miscompares++;
                $display("FAIL missing_plot cyc=%0d got=none exp=(%0d,%0d,%0d)@%0d", cyc, p.x, p.y, p.c, p.cyc);
            end
            vectors++;
            if (plot === 1'b1) begin
                if (pix_q.size() > 0 && pix_q[0].cyc == cyc) begin
                    p = pix_q.pop_front();
                    last_x = p.x; last_y = p.y; last_c = p.c;
                    if ({vga_x, vga_y, vga_colour} !== {p.x, p.y, p.c}) begin
                        miscompares++;
                        $display("FAIL pixel cyc=%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)",
                                 cyc, vga_x, vga_y, vga_colour, p.x, p.y, p.c);
                    end
                end else begin
                    miscompares++;
                    $display("FAIL unexpected_plot cyc=%0d got=(%0d,%0d,%0d) exp=no plot", cyc, vga_x, vga_y, vga_colour);
                end
            end else if (plot !== 1'b0 || {vga_x, vga_y, vga_colour} !== {last_x, last_y, last_c}) begin
                miscompares++;
                $display("FAIL hold cyc=%0d got=plot%b (%0d,%0d,%0d) exp=plot0 (%0d,%0d,%0d)",
                         cyc, plot, vga_x, vga_y, vga_colour, last_x, last_y, last_c);
            end
            while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
                e = ack_q.pop_front();
                vectors++; miscompares++;
                $display("FAIL missing_ack cyc=%0d got=000 exp=%b@%0d", cyc, e.v, e.cyc);
            end
            if (ack !== 3'b000) begin
                vectors++;
                if (ack_q.size() > 0 && ack_q[0].cyc == cyc && ack_q[0].v === ack) void'(ack_q.pop_front());
                else begin miscompares++; $display("FAIL ack cyc=%0d got=%b exp=none-or-other", cyc, ack); end
            end
            while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
                e = done_q.pop_front();
                vectors++; miscompares++;
                $display("FAIL missing_done cyc=%0d got=000 exp=%b@%0d", cyc, e.v, e.cyc);
            end
            if (done !== 3'b000) begin
                vectors++;
                if (done_q.size() > 0 && done_q[0].cyc == cyc && done_q[0].v === done) void'(done_q.pop_front());
                else begin miscompares++; $display("FAIL done cyc=%0d got=%b exp=none-or-other", cyc, done); end
            end
        end
    end

    // Requesters drop their bit in the cycle they see ack
    task automatic step();
        @(negedge Clock);
        #1;
        req = req & ~ack;
    endtask

    task automatic set_fields(input int i, input int x, input int y, input int c);
        req_x[8*i +: 8]      = 8'(x);
        req_y[7*i +: 7]      = 7'(y);
        req_colour[3*i +: 3] = 3'(c);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((req != 3'b000 || m_busy) && n < 3000) begin step(); n++; end
        vectors++;
        if (n >= 3000) begin miscompares++; $display("FAIL wait_idle timeout got=busy exp=idle"); end
        step();
    endtask

    task automatic wait_ack(input int i);
        int n = 0;
        while (ack[i] !== 1'b1 && n < 500) begin step(); n++; end
        vectors++;
        if (n >= 500) begin miscompares++; $display("FAIL wait_ack%0d timeout got=0 exp=1", i); end
    endtask

    initial begin
        logic [2:0] bits;
        Reset = 1'b1;
        repeat (3) step();
        Reset = 1'b0;

        repeat (1000) step();

        set_fields(1, 40, 30, 3'b010);
        req = 3'b010;
        wait_idle();

        set_fields(0, 12, 7, 3'b001);
        set_fields(1, 70, 50, 3'b100);
        set_fields(2, 150, 100, 3'b111);
        req = 3'b111;
        wait_idle();

        set_fields(0, 155, 115, 3'b101);
        req = 3'b001;
        wait_idle();

        set_fields(1, 60, 70, 3'b011);
        set_fields(2, 5, 6, 3'b110);
        req = 3'b110;
        wait_ack(1);
        repeat (36) step();
        Reset = 1'b1;
        step();
        step();
        Reset = 1'b0;
        wait_idle();

        set_fields(1, 10, 20, 3'b001);
        set_fields(2, 120, 100, 3'b010);
        req = 3'b110;
        wait_ack(1);
        repeat (20) step();
        set_fields(2, 30, 40, 3'b100);
        set_fields(0, 80, 90, 3'b111);
        req[0] = 1'b1;
        wait_idle();

        repeat (6) begin
            bits = 3'($urandom_range(7, 1));
            for (int i = 0; i < 3; i++)
                if (bits[i]) set_fields(i, $urandom_range(255, 0), $urandom_range(127, 0), $urandom_range(7, 0));
            req = bits;
            repeat ($urandom_range(150, 0)) step();
            bits = 3'($urandom_range(7, 0)) & ~req;
            for (int i = 0; i < 3; i++)
                if (bits[i]) set_fields(i, $urandom_range(255, 0), $urandom_range(127, 0), $urandom_range(7, 0));
            req = req | bits;
            wait_idle();
        end

        repeat (3) step();
        vectors++;
        if (pix_q.size() + ack_q.size() + done_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover got=%0d pending exp=0", pix_q.size() + ack_q.size() + done_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tile_plot_scheduler.md
Name: tile_plot_scheduler

Overview:
- Shares the single pixel-plot port of the 160x120 VGA adapter between three tile requesters: tail-erase, head-draw and apple-draw.
- Accepts one XDIM x YDIM tile request at a time, using fixed priority.
- Scans the granted tile one pixel per clock, driving x/y/colour/plot.
- Replaces the hand-sequenced draw/erase states in the game top level; sits between the game-logic FSM and vga_adapter.

Parameters:
- XDIM, 10, tile width in pixels (1..16)
- YDIM, 10, tile height in pixels (1..16)
- XSCREEN, 160, horizontal screen size; pixels with x >= XSCREEN are clipped
- YSCREEN, 120, vertical screen size; pixels with y >= YSCREEN are clipped

Ports:
- Clock  in  1  system clock (CLOCK_50 domain)
- Reset  in  1  synchronous, active-high reset
- req  in  3  per-requester tile request; bit 0 highest priority (0=erase, 1=head, 2=apple)
- req_x  in  24  packed tile origin X, 8 bits per requester; requester i uses bits [8i+7:8i]
- req_y  in  21  packed tile origin Y, 7 bits per requester; requester i uses bits [7i+6:7i]
- req_colour  in  9  packed 3-bit colour per requester; requester i uses bits [3i+2:3i]
- ack  out  3  one-cycle pulse: request i accepted, its fields latched
- done  out  3  one-cycle pulse: tile i fully scanned
- busy  out  1  high while a tile is in progress (state != IDLE)
- vga_x  out  8  pixel X to the adapter
- vga_y  out  7  pixel Y to the adapter
- vga_colour  out  3  pixel colour to the adapter
- plot  out  1  pixel write strobe to the adapter

Behaviour:
- Interface: one clock (Clock); Reset is synchronous and active-high. All state updates on posedge Clock.
- Reset:
  - state=IDLE; xc=yc=0; grant=0.
  - ack=000, done=000, busy=0, plot=0, vga_x=0, vga_y=0, vga_colour=0.
  - Takes effect on the next edge, including mid-tile: the tile is abandoned, and no ack or done is issued for it.
- FSM states: IDLE, DRAW, FIN.
- IDLE:
  - When req != 0, grant g = lowest set index.
  - On the edge: latch bx = req_x[g], by = req_y[g], col = req_colour[g]; clear xc, yc; go to DRAW.
  - ack[g] is a registered output and is high during the first DRAW cycle only.
  - When req == 0: stay in IDLE.
- DRAW:
  - One pixel per cycle: vga_x = bx + xc, vga_y = by + yc, vga_colour = col.
  - xc increments each cycle. When xc == XDIM-1: xc returns to 0 and yc increments.
  - When xc == XDIM-1 and yc == YDIM-1, go to FIN.
  - Exactly XDIM*YDIM DRAW cycles per tile.
- FIN:
  - done[g] = 1 and plot = 0 for one cycle, then go to IDLE.
  - IDLE samples req on the following cycle.
  - Throughput: XDIM*YDIM + 2 cycles per tile, including the IDLE grant cycle.
- Outputs are registered, with no combinational path from req to plot.
  - vga_x, vga_y and vga_colour hold their last values when plot = 0.
- Arithmetic and clipping:
  - Sums are computed at 9 bits (X) and 8 bits (Y).
  - plot = 1 in DRAW only if sumX < XSCREEN and sumY < YSCREEN.
  - A clipped pixel still consumes its cycle; the counters advance normally.
  - vga_x and vga_y carry the low 8 and 7 bits of the sums.
- Handshake:
  - A requester holds req and its fields stable until it sees ack, then drops req in that cycle.
  - A req still high when the FSM next returns to IDLE is treated as a new request.
  - req changes during DRAW do not affect the tile in progress.
- Arbitration:
  - Strict fixed priority, evaluated only in IDLE.
  - Simultaneous requests are served one per tile in index order, as long as they persist.
  - Requester 2 may starve. This is accepted by design: game logic issues at most one erase and one head tile per move tick.

Decomposition:
- Shared package (snake_pkg): XDIM, YDIM, XSCREEN, YSCREEN constants; requester index constants REQ_ERASE=0, REQ_HEAD=1, REQ_APPLE=2; FSM state encoding.
- One natural sub-module: tile_scan_counter.
  - Holds the XC/YC counters, with load and enable inputs.
  - Outputs the last_pixel flag.
  - Instantiated once by the scheduler; reuses the existing UpDn_count style.

Test Plan:
- Reset, then req=010, req_x[15:8]=40, req_y[13:7]=30, colour[5:3]=3'b010:
  - ack[1] one cycle later.
  - 100 plot cycles covering (40..49, 30..39) in row-major order, colour 010.
  - Then done[1] pulse; busy low 102 cycles after req rose.
- req=111 held continuously, with each requester dropping its bit on its ack:
  - Grants in order 0, 1, 2.
  - Each tile is 100 plots; no overlap; each done precedes the next ack.
- Clipping: origin (155,115), req=001 → plot high for exactly 25 cycles (x 155..159, y 115..119); done[0] still after 100 DRAW cycles.
- Reset asserted on the 37th DRAW cycle → next cycle plot=0, busy=0, ack=done=000; no done pulse for the aborted tile; a held req is re-granted after Reset drops.
- req[2] changes its fields and req[0] rises mid-tile → current tile's coordinates and colour unchanged; req[0] granted next, ahead of the pending req[2].
- Idle stability: req=000 for 1000 cycles after reset → plot, ack, done and busy all remain 0.
